// File: rtl/lcd_note_writer.sv
// lcd_note_writer
//
// Writes a four-character note to an HD44780-style LCD. One start request
// produces five bus writes: a "set DDRAM address" command (0x80 | START_ADDR)
// followed by the four bytes of the latched char_word, leftmost first. Each
// write is a SETUP phase (data/RS valid, EN low), a PULSE phase (EN high) and
// a WAIT phase (EN low, LCD executing). One down-counter times all phases.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   char_word  in   [31:24] leftmost .. [7:0] rightmost ASCII character
//   start      in   sequence request, only sampled while idle
//   lcd_data   out  LCD data bus, held at the last written value when idle
//   lcd_rs     out  0 = command, 1 = character data
//   lcd_rw     out  always 0 (write only)
//   lcd_en     out  LCD enable strobe
//   busy       out  high for the whole five-write sequence
//   done       out  one-cycle pulse in the first idle cycle after a sequence

module lcd_note_writer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned EN_CYC     = 12,
    parameter int unsigned WAIT_CYC   = 2500,
    parameter logic [7:0]  START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] char_word,
    input  logic        start,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        busy,
    output logic        done
);

    // The counter is loaded with (phase length - 1) and counts down to zero,
    // so it only needs to hold the largest phase length minus one.
    localparam int unsigned MaxSw  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MaxCyc = (MaxSw > WAIT_CYC) ? MaxSw : WAIT_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] SetupLoad = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] EnLoad    = CntW'(EN_CYC - 1);
    localparam logic [CntW-1:0] WaitLoad  = CntW'(WAIT_CYC - 1);

    localparam logic [7:0] AddrCmd = 8'h80 | START_ADDR;
    localparam logic [2:0] LastIdx = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StPulse,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            done_q, done_d;

    // Character for the write that follows the current one (idx_q + 1).
    logic [7:0]      next_char;

    always_comb begin
        next_char = word_q[7:0];
        unique case (idx_q)
            3'd0:    next_char = word_q[31:24];
            3'd1:    next_char = word_q[23:16];
            3'd2:    next_char = word_q[15:8];
            default: next_char = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Bus values are loaded on the accepting edge so they are
                // already valid in the first SETUP cycle.
                if (start) begin
                    word_d  = char_word;
                    idx_d   = 3'd0;
                    data_d  = AddrCmd;
                    rs_d    = 1'b0;
                    cnt_d   = SetupLoad;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = EnLoad;
                    state_d = StPulse;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StPulse: begin
                if (cnt_q == '0) begin
                    cnt_d   = WaitLoad;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StWait: begin
                if (cnt_q == '0) begin
                    if (idx_q < LastIdx) begin
                        idx_d   = idx_q + 3'd1;
                        data_d  = next_char;
                        rs_d    = 1'b1;
                        cnt_d   = SetupLoad;
                        state_d = StSetup;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            word_q  <= 32'h0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            done_q  <= done_d;
        end
    end

    // lcd_en and busy decode straight from the state register so that the
    // asynchronous reset drops them immediately.
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = (state_q == StPulse);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_lcd_note_writer.sv
module tb_lcd_note_writer;

    localparam int unsigned SetupCyc = 1;
    localparam int unsigned EnCyc    = 2;
    localparam int unsigned WaitCyc  = 3;
    localparam int unsigned SeqLen   = 5 * (SetupCyc + EnCyc + WaitCyc);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] char_word;
    logic        start;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, busy, done;

    logic        start2;
    logic [7:0]  lcd_data2;
    logic        lcd_rs2, lcd_rw2, lcd_en2, busy2, done2;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;

    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    lcd_note_writer #(
        .SETUP_CYC (SetupCyc),
        .EN_CYC    (EnCyc),
        .WAIT_CYC  (WaitCyc),
        .START_ADDR(8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .char_word(char_word),
        .start    (start),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .busy     (busy),
        .done     (done)
    );

    lcd_note_writer #(
        .SETUP_CYC (SetupCyc),
        .EN_CYC    (EnCyc),
        .WAIT_CYC  (WaitCyc),
        .START_ADDR(8'h40)
    ) dut_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .char_word(char_word),
        .start    (start2),
        .lcd_data (lcd_data2),
        .lcd_rs   (lcd_rs2),
        .lcd_rw   (lcd_rw2),
        .lcd_en   (lcd_en2),
        .busy     (busy2),
        .done     (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] w, input logic [7:0] addr_cmd);
        exp_q.push_back({1'b0, addr_cmd});
        exp_q.push_back({1'b1, w[31:24]});
        exp_q.push_back({1'b1, w[23:16]});
        exp_q.push_back({1'b1, w[15:8]});
        exp_q.push_back({1'b1, w[7:0]});
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    // Bus monitor / scoreboard / protocol checker for the main instance.
    logic       prev_en, prev_busy, prev_rs;
    logic [7:0] prev_data;
    int         en_len, busy_len;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_busy = 1'b0;
            prev_rs   = 1'b0;
            prev_data = 8'h00;
            en_len    = 0;
            busy_len  = 0;
        end else begin
            chk("rw_low", {31'h0, lcd_rw}, 32'h0);
            if (lcd_en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {23'h0, lcd_rs, lcd_data}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {23'h0, lcd_rs, lcd_data}, {23'h0, e});
                end
            end
            if (lcd_en || prev_en)
                chk("bus_stable", {23'h0, lcd_rs, lcd_data}, {23'h0, prev_rs, prev_data});
            if (lcd_en) en_len++;
            if (!lcd_en && prev_en) begin
                chk("en_len", en_len, EnCyc);
                en_len = 0;
            end
            if (busy) busy_len++;
            if (!busy && prev_busy) begin
                chk("busy_len", busy_len, SeqLen);
                busy_len = 0;
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", {31'h0, busy}, 32'h0);
                chk("done_after_busy", {31'h0, prev_busy}, 32'h1);
            end
            prev_en   = lcd_en;
            prev_busy = busy;
            prev_rs   = lcd_rs;
            prev_data = lcd_data;
        end
    end

    initial begin
        bit seen;
        int done_before;

        rst_n     = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        char_word = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_data", lcd_data, 32'h0);
        chk("rst_rs", lcd_rs, 32'h0);
        chk("rst_rw", lcd_rw, 32'h0);
        chk("rst_en", lcd_en, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_data2", lcd_data2, 32'h0);
        chk("rst_busy2", busy2, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write of " Do1".
        char_word = 32'h20446F31;
        push_seq(32'h20446F31, 8'h80);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("basic_busy_rise", busy, 32'h1);
        chk("basic_first_data", lcd_data, 32'h80);
        chk("basic_first_rs", lcd_rs, 32'h0);
        chk("basic_setup_en", lcd_en, 32'h0);
        wait_done(SeqLen + 5, seen);
        chk("basic_done_seen", {31'h0, seen}, 32'h1);
        @(negedge clk);
        chk("basic_done_one_cycle", done, 32'h0);
        chk("idle_hold_data", lcd_data, 32'h31);
        chk("idle_hold_rs", lcd_rs, 32'h1);
        chk("idle_en", lcd_en, 32'h0);
        chk("basic_queue_empty", exp_q.size(), 32'h0);

        // Busy lockout: start and word change at cycle 10 are ignored.
        repeat (2) @(negedge clk);
        done_before = done_cnt;
        push_seq(32'h20446F31, 8'h80);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        char_word = 32'h20205265;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(SeqLen + 5, seen);
        chk("lock_done_seen", {31'h0, seen}, 32'h1);
        repeat (SeqLen) @(negedge clk);
        chk("lock_single_done", done_cnt, done_before + 1);
        chk("lock_idle", busy, 32'h0);
        chk("lock_queue_empty", exp_q.size(), 32'h0);

        // Back-to-back with start held high.
        char_word = 32'h4C434431;
        push_seq(32'h4C434431, 8'h80);
        push_seq(32'h4C434431, 8'h80);
        start = 1'b1;
        wait_done(SeqLen + 5, seen);
        chk("b2b_first_done", {31'h0, seen}, 32'h1);
        chk("b2b_gap_busy_low", busy, 32'h0);
        @(negedge clk);
        chk("b2b_restart_busy", busy, 32'h1);
        chk("b2b_restart_data", lcd_data, 32'h80);
        start = 1'b0;
        wait_done(SeqLen + 5, seen);
        chk("b2b_second_done", {31'h0, seen}, 32'h1);
        @(negedge clk);
        chk("b2b_queue_empty", exp_q.size(), 32'h0);

        // Reset during the first enable pulse.
        repeat (2) @(negedge clk);
        char_word = 32'h20446F31;
        exp_q.push_back(9'h080);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (lcd_en) seen = 1'b1;
        end
        chk("rstmid_en_seen", {31'h0, seen}, 32'h1);
        done_before = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_en", lcd_en, 32'h0);
        chk("rstmid_busy", busy, 32'h0);
        chk("rstmid_data", lcd_data, 32'h0);
        chk("rstmid_rs", lcd_rs, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (SeqLen) @(negedge clk);
        chk("rstmid_no_done", done_cnt, done_before);
        chk("rstmid_idle", busy, 32'h0);
        char_word = 32'h41424344;
        push_seq(32'h41424344, 8'h80);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rstmid_restart_data", lcd_data, 32'h80);
        wait_done(SeqLen + 5, seen);
        chk("rstmid_restart_done", {31'h0, seen}, 32'h1);
        @(negedge clk);
        chk("rstmid_queue_empty", exp_q.size(), 32'h0);

        // START_ADDR = 0x40 instance: first write is command 0xC0.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (lcd_en2) seen = 1'b1;
            else @(negedge clk);
        end
        chk("addr_en_seen", {31'h0, seen}, 32'h1);
        chk("addr_cmd_data", lcd_data2, 32'hC0);
        chk("addr_cmd_rs", lcd_rs2, 32'h0);
        chk("addr_rw", lcd_rw2, 32'h0);
        repeat (SeqLen + 5) @(negedge clk);
        chk("addr_done_idle", busy2, 32'h0);

        chk("total_done_pulses", done_cnt, 32'd5);
        chk("final_queue_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_note_writer.md
LCD_NOTE_WRITER -- requirements
Module: lcd_note_writer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles data and RS are stable with lcd_en low before each enable pulse (minimum 1).
REQ-002 SHALL have parameter EN_CYC, default 12: cycles lcd_en is held high per write (minimum 1).
REQ-003 SHALL have parameter WAIT_CYC, default 2500: cycles after lcd_en falls before the next write (50 us at 50 MHz; minimum 1).
REQ-004 SHALL have parameter START_ADDR, default 8'h00: LCD DDRAM address of the first character.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port char_word, input, 32: four packed ASCII characters; [31:24] is the leftmost character.
REQ-008 SHALL have port start, input, 1: request to write char_word to the LCD; sampled only in IDLE.
REQ-009 SHALL have port lcd_data, output, 8: HD44780 data bus.
REQ-010 SHALL have port lcd_rs, output, 1: 0 means command, 1 means character data.
REQ-011 SHALL have port lcd_rw, output, 1: tied to 0 (write only).
REQ-012 SHALL have port lcd_en, output, 1: LCD enable strobe.
REQ-013 SHALL have port busy, output, 1: high while a sequence is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.

Function
REQ-015 SHALL implement the states IDLE, SETUP, PULSE and WAIT, with a write index idx in the range 0..4 and a single down-counter for timing.
REQ-016 When start is high at a clock edge in IDLE, the block SHALL latch char_word, set idx=0, and enter SETUP; busy SHALL be high from the next cycle.
REQ-017 The write at idx=0 SHALL be the command lcd_rs=0, lcd_data=8'h80|START_ADDR.
REQ-018 The writes at idx=1..4 SHALL be lcd_rs=1 with lcd_data equal to latched bytes [31:24], [23:16], [15:8] and [7:0], in that order.
REQ-019 SETUP SHALL last SETUP_CYC cycles with lcd_en=0, then transition to PULSE.
REQ-020 PULSE SHALL last EN_CYC cycles with lcd_en=1, then transition to WAIT.
REQ-021 WAIT SHALL last WAIT_CYC cycles with lcd_en=0; at its end, if idx<4 the block SHALL increment idx and enter SETUP, otherwise it SHALL enter IDLE.
REQ-022 lcd_data and lcd_rs SHALL stay constant from the first SETUP cycle through the last WAIT cycle of each write.
REQ-023 The sequence length SHALL be exactly 5*(SETUP_CYC+EN_CYC+WAIT_CYC) cycles of busy=1.
REQ-024 done SHALL be high for exactly one cycle, the first IDLE cycle after the sequence; busy SHALL be 0 in that cycle.
REQ-025 start SHALL be ignored while busy=1 and SHALL NOT be queued; changes to char_word mid-sequence SHALL NOT affect the bytes written.
REQ-026 start held high continuously SHALL begin a new sequence on the edge at which done is high, so busy is low for exactly one cycle.
REQ-027 In IDLE, lcd_data and lcd_rs SHALL hold the last written values and lcd_en SHALL be 0.

Reset
REQ-028 While rst_n=0, the block SHALL immediately, without waiting for clk, set state=IDLE, idx=0, counter=0, lcd_data=8'h00, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=0, done=0, and clear the latched word.
REQ-029 Reset asserted mid-sequence SHALL abort the sequence with no done pulse; the first start after release SHALL begin again at idx=0.

Verification (SETUP_CYC=1, EN_CYC=2, WAIT_CYC=3, START_ADDR=8'h00)
REQ-030 Basic write: char_word=" Do1" (32'h20446F31), one-cycle start -> the writes 80(rs0), 20, 44, 6F, 31(rs1) in order; each has lcd_en high for 2 cycles; busy is high for 30 cycles, then done pulses once.
REQ-031 Busy lockout: a start pulse at cycle 10 of a sequence, with char_word changed to "  Re" -> ignored; the bytes still match " Do1"; only one done pulse.
REQ-032 Back-to-back: start held high -> a second sequence begins in the done cycle; busy is low for exactly 1 cycle between sequences.
REQ-033 Reset mid-pulse: rst_n dropped while lcd_en=1 -> lcd_en, busy and lcd_data go to 0 before the next clk edge; no done pulse; a new start after release writes 80 first.
REQ-034 Address parameter: START_ADDR=8'h40 -> the first write is lcd_data=8'hC0 with lcd_rs=0.
REQ-035 Protocol checker: lcd_rw=0 always; lcd_data and lcd_rs never change while lcd_en=1 or in the cycle lcd_en falls.
